instruction_dispatch_fifo: RTL



---
 rtl/instruction_dispatch_fifo.sv | 89 ++++++++
 1 files changed

// File: rtl/instruction_dispatch_fifo.sv
// instruction_dispatch_fifo: buffers host instructions and issues them to the coordinator in order.
// Define INSTR_DISPATCH_STATS_EN to add the issued_cnt and high_water statistics outputs.
module instruction_dispatch_fifo #(
    parameter int INSTR_WIDTH = 80,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [INSTR_WIDTH-1:0] host_instr,
    input  logic                   host_valid,
    output logic                   host_ready,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instruction_en,
    input  logic                   busy,
    output logic [CNT_W-1:0]       count,
`ifdef INSTR_DISPATCH_STATS_EN
    output logic [31:0]            issued_cnt,
    output logic [CNT_W-1:0]       high_water,
`endif
    output logic                   empty,
    output logic                   full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push, pop;

    assign empty          = count_q == '0;
    assign full           = count_q == CNT_W'(DEPTH);
    // Held low during reset so the host sees no acceptance until rst_n releases.
    assign host_ready     = rst_n && !full && !flush;
    assign instruction_en = !empty && enable && !flush;
    assign push           = host_valid && host_ready;
    assign pop            = instruction_en && !busy;
    assign instruction    = mem_q[rd_ptr_q];
    assign count          = count_q;

    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
        count_d  = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= host_instr;
    end

`ifdef INSTR_DISPATCH_STATS_EN
    logic [31:0]      issued_q, issued_d;
    logic [CNT_W-1:0] high_water_q, high_water_d;

    // Tracks the next count so high_water never trails the current occupancy.
    always_comb begin
        issued_d     = issued_q + 32'(pop);
        high_water_d = count_d > high_water_q ? count_d : high_water_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q     <= '0;
            high_water_q <= '0;
        end else begin
            issued_q     <= issued_d;
            high_water_q <= high_water_d;
        end
    end

    assign issued_cnt = issued_q;
    assign high_water = high_water_q;
`endif
endmodule
